// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes and
// streams frames out through a small FIFO with tlast/tuser framing.
module mii_rx_deframer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        aresetn,
  input  logic [3:0]  mii_rxd,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  output logic [7:0]  maxis_tdata,
  output logic        maxis_tvalid,
  input  logic        maxis_tready,
  output logic        maxis_tlast,
  output logic        maxis_tuser,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DATA_LO,
    S_DATA_HI,
    S_DISCARD
  } state_t;

  state_t             state_q, state_d;
  logic               seen5_q, seen5_d;
  logic [3:0]         low_q, low_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   mem_count_q, mem_count_d;
  logic               out_valid_q, out_valid_d;
  logic [9:0]         out_data_q, out_data_d;

  logic [9:0]         mem [FIFO_DEPTH];
  logic               push;
  logic [9:0]         push_data;
  logic               pop;
  logic               load;
  logic               err_now;
  logic               eof_user;
  logic [CNT_W-1:0]   fifo_count;
  logic               room;

  // The output register counts as a FIFO slot so the reserved-slot rule is exact.
  assign fifo_count = mem_count_q + {{(CNT_W-1){1'b0}}, out_valid_q};
  assign room       = fifo_count < CNT_W'(FIFO_DEPTH - 1);
  assign err_now    = err_q | mii_rx_er;
  assign eof_user   = err_now | (state_q == S_DATA_HI);

  always_comb begin
    state_d       = state_q;
    seen5_d       = seen5_q;
    low_d         = low_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    err_d         = err_q;
    ovf_d         = ovf_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    push          = 1'b0;
    push_data     = 10'd0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (!mii_rx_dv) state_d = S_IDLE;
      end
      S_IDLE: begin
        seen5_d = 1'b0;
        if (mii_rx_dv) begin
          if (mii_rxd == 4'h5) begin
            seen5_d = 1'b1;
            state_d = S_PREAMBLE;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_PREAMBLE: begin
        if (!mii_rx_dv) begin
          state_d = S_IDLE;
        end else if (mii_rxd == 4'h5) begin
          seen5_d = 1'b1;
        end else if (mii_rxd == 4'hD && seen5_q) begin
          state_d      = S_DATA_LO;
          err_d        = 1'b0;
          ovf_d        = 1'b0;
          hold_valid_d = 1'b0;
        end else begin
          state_d = S_DISCARD;
        end
      end
      S_DATA_LO, S_DATA_HI: begin
        if (!mii_rx_dv) begin
          state_d      = S_IDLE;
          hold_valid_d = 1'b0;
          if (ovf_q) begin
            push         = 1'b1;
            push_data    = {8'h00, 1'b1, 1'b1};
            drop_count_d = drop_count_q + 16'd1;
          end else if (hold_valid_q) begin
            push      = 1'b1;
            push_data = {hold_q, 1'b1, eof_user};
            if (!eof_user) frame_count_d = frame_count_q + 16'd1;
          end
        end else if (state_q == S_DATA_LO) begin
          low_d   = mii_rxd;
          err_d   = err_now;
          state_d = S_DATA_HI;
        end else begin
          err_d        = err_now;
          state_d      = S_DATA_LO;
          hold_d       = {mii_rxd, low_q};
          hold_valid_d = 1'b1;
          // Once a frame overflows, every later byte of it is dropped.
          if (hold_valid_q && !ovf_q) begin
            if (room) begin
              push      = 1'b1;
              push_data = {hold_q, 1'b0, 1'b0};
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      S_DISCARD: begin
        if (!mii_rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    pop         = out_valid_q & maxis_tready;
    load        = (mem_count_q != '0) && (!out_valid_q || pop);
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    out_data_d  = load ? mem[rd_ptr_q] : out_data_q;
    out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    mem_count_d = mem_count_q;
    if (push && !load)      mem_count_d = mem_count_q + CNT_W'(1);
    else if (!push && load) mem_count_d = mem_count_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state_q       <= S_WAIT_IDLE;
      seen5_q       <= 1'b0;
      low_q         <= 4'd0;
      hold_q        <= 8'd0;
      hold_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      frame_count_q <= 16'd0;
      drop_count_q  <= 16'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 10'd0;
    end else begin
      state_q       <= state_d;
      seen5_q       <= seen5_d;
      low_q         <= low_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

  assign maxis_tvalid = out_valid_q;
  assign maxis_tdata  = out_data_q[9:2];
  assign maxis_tlast  = out_data_q[1];
  assign maxis_tuser  = out_data_q[0];
  assign frame_count  = frame_count_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Bench for mii_rx_deframer: directed and random frames scored against a
// frame-level expectation queue built from the deframing rules.
module tb_mii_rx_deframer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  rxd = 4'd0;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        tready = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser;
  logic [15:0] frame_count, drop_count;

  mii_rx_deframer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .aresetn(aresetn),
    .mii_rxd(rxd), .mii_rx_dv(dv), .mii_rx_er(er),
    .maxis_tdata(tdata), .maxis_tvalid(tvalid), .maxis_tready(tready),
    .maxis_tlast(tlast), .maxis_tuser(tuser),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  int exp_frames = 0;
  int exp_drops = 0;
  int ready_mode = 1;
  logic [7:0] tx_bytes[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // tready pattern: 0 = held low, 1 = held high, otherwise toggles each cycle.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0: tready = 1'b0;
      1: tready = 1'b1;
      default: tready = ~tready;
    endcase
  end

  // Output monitor: scoreboard compare on every handshake and hold check on stalls.
  initial begin
    logic       stall_prev;
    logic [9:0] prev_beat;
    logic [9:0] beat;
    stall_prev = 1'b0;
    prev_beat  = 10'd0;
    forever begin
      @(negedge clock);
      beat = {tdata, tlast, tuser};
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_tvalid", {31'd0, tvalid}, 32'd1);
          check("hold_beat", {22'd0, beat}, {22'd0, prev_beat});
        end
        if (tvalid && tready) begin
          check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) check("beat", {22'd0, beat}, {22'd0, exp_q.pop_front()});
        end
        stall_prev = tvalid && !tready;
        prev_beat  = beat;
      end
    end
  end

  task automatic drive_nib(input logic [3:0] n, input logic v, input logic e);
    @(posedge clock);
    #2;
    rxd = n;
    dv  = v;
    er  = e;
  endtask

  // Sends tx_bytes as one frame and queues the beats the rules predict.
  task automatic send_frame(input int pre5, input bit bad_pre, input bit odd,
                            input int er_nib, input bit stall, input int gap);
    logic [3:0] nib[$];
    bit         erq[$];
    int         nbytes;
    bit         err;
    nbytes = tx_bytes.size();
    for (int i = 0; i < pre5; i++) begin nib.push_back(4'h5); erq.push_back(1'b0); end
    nib.push_back(bad_pre ? 4'h3 : 4'hD);
    erq.push_back(1'b0);
    for (int i = 0; i < nbytes; i++) begin
      nib.push_back(tx_bytes[i][3:0]); erq.push_back(er_nib == 2 * i);
      nib.push_back(tx_bytes[i][7:4]); erq.push_back(er_nib == 2 * i + 1);
    end
    if (odd) begin nib.push_back(4'($urandom)); erq.push_back(er_nib == 2 * nbytes); end
    if (!bad_pre && nbytes > 0) begin
      err = (er_nib >= 0) || odd;
      if (stall && nbytes - 1 > DEPTH - 1) begin
        for (int i = 0; i < DEPTH - 1; i++) exp_q.push_back({tx_bytes[i], 2'b00});
        exp_q.push_back({8'h00, 2'b11});
        exp_drops++;
      end else begin
        for (int i = 0; i < nbytes - 1; i++) exp_q.push_back({tx_bytes[i], 2'b00});
        exp_q.push_back({tx_bytes[nbytes-1], 1'b1, err});
        if (!err) exp_frames++;
      end
    end
    foreach (nib[i]) drive_nib(nib[i], 1'b1, erq[i]);
    drive_nib(4'd0, 1'b0, 1'b0);
    repeat (gap - 1) @(posedge clock);
    $display("frame bytes=%0d pre5=%0d bad_pre=%0d odd=%0d er_nib=%0d stall=%0d queued=%0d",
             nbytes, pre5, bad_pre, odd, er_nib, stall, exp_q.size());
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    check({tag, "_drain"}, {31'd0, n < 3000}, 32'd1);
    check({tag, "_frame_count"}, {16'd0, frame_count}, exp_frames & 32'hFFFF);
    check({tag, "_drop_count"}, {16'd0, drop_count}, exp_drops & 32'hFFFF);
  endtask

  task automatic fill_seq(input logic [7:0] first, input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(first + 8'(i));
  endtask

  task automatic fill_rand(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", {24'd0, tdata}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_tuser", {31'd0, tuser}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    @(posedge clock);
    #2 aresetn = 1'b1;
    repeat (3) @(posedge clock);

    ready_mode = 1;
    fill_seq(8'h00, 64);
    send_frame(15, 1'b0, 1'b0, -1, 1'b0, 4);
    wait_drain("normal");

    fill_rand(10);
    send_frame(7, 1'b0, 1'b0, 9, 1'b0, 3);
    wait_drain("rx_er");

    fill_rand(8);
    send_frame(7, 1'b0, 1'b1, -1, 1'b0, 3);
    wait_drain("odd");

    ready_mode = 0;
    repeat (3) @(posedge clock);
    fill_seq(8'hA0, 20);
    send_frame(15, 1'b0, 1'b0, -1, 1'b1, 2);
    repeat (5) @(posedge clock);
    ready_mode = 1;
    wait_drain("overflow");

    fill_rand(6);
    send_frame(2, 1'b1, 1'b0, -1, 1'b0, 3);
    repeat (20) @(posedge clock);
    wait_drain("bad_preamble");

    // Reset in the middle of a stalled frame; the tail of that frame must be ignored.
    ready_mode = 0;
    for (int i = 0; i < 7; i++) drive_nib(4'h5, 1'b1, 1'b0);
    drive_nib(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive_nib(4'($urandom), 1'b1, 1'b0);
    @(posedge clock);
    #2 aresetn = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    repeat (3) @(posedge clock);
    #2 aresetn = 1'b1;
    for (int i = 0; i < 10; i++) drive_nib(4'($urandom), 1'b1, 1'b0);
    drive_nib(4'd0, 1'b0, 1'b0);
    ready_mode = 1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("post_reset_tvalid", {31'd0, tvalid}, 32'd0);
    wait_drain("mid_reset");
    fill_rand(12);
    send_frame(15, 1'b0, 1'b0, -1, 1'b0, 3);
    wait_drain("after_reset");

    ready_mode = 2;
    fill_rand(4);
    send_frame(7, 1'b0, 1'b0, -1, 1'b0, 1);
    fill_rand(4);
    send_frame(7, 1'b0, 1'b0, -1, 1'b0, 1);
    wait_drain("back_to_back");

    for (int f = 0; f < 30; f++) begin
      ready_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
      fill_rand($urandom_range(1, 30));
      send_frame($urandom_range(1, 15), ($urandom_range(0, 7) == 0),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * tx_bytes.size() - 1) : -1,
                 1'b0, $urandom_range(1, 5));
    end
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mii_rx_deframer.md
# mii_rx_deframer

Receive-side MII front end of the Ethernet MAC. Samples the 4-bit MII receive interface, strips preamble and SFD, assembles nibbles into bytes and delivers each frame as a byte-wide AXI-Stream with `tlast` on the final byte and `tuser` flagging a bad frame. Its output feeds the CRC-stripping stage directly, so the stream still carries the 4-byte FCS. A small FIFO absorbs downstream backpressure, because MII cannot be stalled.

## Interface
- `FIFO_DEPTH`, 16: output FIFO entries (power of two, ≥4). Each entry is {tdata[7:0], tlast, tuser}.
- `clock` input 1: MII RX clock; all logic on the rising edge.
- `aresetn` input 1: reset, synchronous, active-low.
- `mii_rxd` input 4: receive nibble, low nibble of each byte first.
- `mii_rx_dv` input 1: receive data valid.
- `mii_rx_er` input 1: receive error.
- `maxis_tdata` output 8: frame byte.
- `maxis_tvalid` output 1: beat valid.
- `maxis_tready` input 1: downstream ready.
- `maxis_tlast` output 1: last byte of frame.
- `maxis_tuser` output 1: frame error; meaningful only with `tlast`, 0 on all other beats.
- `frame_count` output 16: frames terminated with tuser=0, wraps.
- `drop_count` output 16: frames terminated with tuser=1 due to FIFO overflow, wraps.

## Operation
- States:
  - S_WAIT_IDLE: entered on reset; moves to S_IDLE on the first cycle with rx_dv=0. Prevents capturing a frame that was already in progress.
  - S_IDLE: rx_dv=1 moves to S_PREAMBLE; the current nibble is evaluated as a preamble nibble.
  - S_PREAMBLE: nibble 0x5 sets `seen5`. Nibble 0xD with `seen5` moves to S_DATA_LO. 0xD without `seen5`, or any other nibble, moves to S_DISCARD. rx_dv=0 returns to S_IDLE with no output.
  - S_DATA_LO: latches the low nibble, then S_DATA_HI.
  - S_DATA_HI: forms byte {rxd, low} and pushes it into the hold stage (below), then S_DATA_LO.
  - S_DISCARD: waits for rx_dv=0, then S_IDLE. Nothing is emitted.
- Hold stage: one byte register `hold` with `hold_valid`.
  - When a new byte completes and `hold_valid`=1, `hold` is written to the FIFO with tlast=0 and the new byte replaces it.
- End of frame: rx_dv=0 while in S_DATA_LO/S_DATA_HI.
  - If `hold_valid`, `hold` is written with tlast=1 and tuser=err.
  - err = (rx_er seen anywhere in the frame) OR (end occurred in S_DATA_HI, i.e. an odd nibble count; the partial nibble is discarded).
  - If no byte completed (rx_dv fell right after the SFD), nothing is written and no counter changes.
  - Next state is S_IDLE. rx_dv may rise again on the very next cycle.
- Overflow:
  - A data write (tlast=0) is permitted only while FIFO count < FIFO_DEPTH−1, which keeps one slot reserved.
  - A data write attempted at count ≥ FIFO_DEPTH−1 is dropped and sets `ovf`. All further bytes of that frame are dropped, including `hold`.
  - At end of frame with `ovf`, a terminator {0x00, tlast=1, tuser=1} goes into the reserved slot, which is guaranteed free. drop_count increments; frame_count does not.
  - An end-of-frame write always succeeds.
- frame_count increments when a tlast=1, tuser=0 entry is written into the FIFO.
- rx_er while in S_IDLE or S_PREAMBLE is ignored. rx_er in the data states sets the per-frame err flag, which is cleared when a new frame starts.
- Reset mid-frame: the FIFO is emptied, any partial frame is lost, and the block enters S_WAIT_IDLE.

## Timing
- Reset values:
  - maxis_tvalid=0, maxis_tdata=0, maxis_tlast=0, maxis_tuser=0.
  - frame_count=0, drop_count=0.
  - FIFO empty, hold_valid=0, state S_WAIT_IDLE.
- FIFO has registered outputs; a beat transfers on tvalid && tready.
  - tvalid rises the cycle after the first write into an empty FIFO.
- Latency:
  - Byte k is complete at its high-nibble edge T.
  - It is written at T+2 (next byte completes) or at the rx_dv-fall edge.
  - It appears on maxis one cycle after that write.
- The FIFO supports a read and a write in the same cycle. Count is unchanged in that case, and the reservation check uses the count before that cycle.
- Outputs hold steady while tvalid=1 and tready=0.

## Test plan
- Normal frame, tready=1: 15 nibbles 0x5, 0xD, then bytes 0x00..0x3F, rx_dv low → 64 beats 0x00..0x3F, tlast only on 0x3F, tuser=0, frame_count=1.
- rx_er pulsed for 1 cycle mid-frame in a 10-byte frame → all 10 bytes delivered, tuser=1 only on the tlast beat, frame_count=0.
- Odd nibble: 8-byte frame plus one extra nibble → 8 beats, last byte correct, tlast with tuser=1.
- Overflow, FIFO_DEPTH=16, tready=0, 20-byte frame 0xA0..0xB3, then tready=1 → beats 0xA0..0xAE (15), then 0x00 with tlast=1, tuser=1; drop_count=1.
- Preamble corruption (0x5,0x5,0x3,…) and reset asserted mid-frame → no output. After reset, a frame already in progress is ignored until rx_dv=0; the next frame is received normally.
- Back-to-back 4-byte frames separated by 1 idle cycle, tready toggling 1/0 each cycle → both frames intact, in order, frame_count=2.
